// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front end and gate controller.
// Keypad state encoding, digit width and the cleared-code value.
package parking_pkg;
  localparam int KEY_W = 2;
  localparam logic [KEY_W-1:0] CODE_CLEAR = 2'b00;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_FIRST = 2'd1,
    K_DONE  = 2'd2
  } key_state_e;
endpackage

// File: rtl/sensor_debounce.sv
// 2-FF synchroniser plus debounce counter; output flips after DEBOUNCE_CYCLES mismatching samples.
// Latency 1+DEBOUNCE_CYCLES edges from first sampling edge; no backpressure (level in, level out).
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_out
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw_in};
    level_d = level_q;
    cnt_d   = '0;
    // sync_q[1] is the synchronised sample; any agreement restarts the count
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;
endmodule

// File: rtl/parking_input_conditioner.sv
// Debounces entrance/exit sensors and assembles two keypad digits into a published code pair.
// Code valid the cycle after the second digit; no backpressure, keys are strobes that are never stalled.
// Optional idle timeout in K_FIRST enabled by defining PARKING_KEYPAD_TIMEOUT_EN.
module parking_input_conditioner
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int KEY_TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_clear,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic [KEY_W-1:0] password_1,
  output logic [KEY_W-1:0] password_2,
  output logic             pass_ready,
  output logic             entry_busy
);
  if (DEBOUNCE_CYCLES < 2 || KEY_TIMEOUT < 1) begin : g_param_check
    $error("parking_input_conditioner: DEBOUNCE_CYCLES must be >= 2 and KEY_TIMEOUT >= 1");
  end

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_entrance),
    .level_out (sensor_entrance)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_exit),
    .level_out (sensor_exit)
  );

  key_state_e       state_q, state_d;
  logic [KEY_W-1:0] digit1_q, digit1_d;
  logic [KEY_W-1:0] pw1_q, pw1_d;
  logic [KEY_W-1:0] pw2_q, pw2_d;
  logic             ready_q, ready_d;

`ifdef PARKING_KEYPAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(KEY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(KEY_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    digit1_d = digit1_q;
    pw1_d    = pw1_q;
    pw2_d    = pw2_q;
    ready_d  = 1'b0;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    if (key_clear) begin
      state_d  = K_IDLE;
      digit1_d = CODE_CLEAR;
      pw1_d    = CODE_CLEAR;
      pw2_d    = CODE_CLEAR;
    end else begin
      unique case (state_q)
        K_IDLE, K_DONE: begin
          if (key_valid) begin
            digit1_d = key_code;
            state_d  = K_FIRST;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end
        end
        K_FIRST: begin
          // both digits load on the same edge so the pair never tears
          if (key_valid) begin
            pw1_d   = digit1_q;
            pw2_d   = key_code;
            ready_d = 1'b1;
            state_d = K_DONE;
          end
`ifdef PARKING_KEYPAD_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            digit1_d = CODE_CLEAR;
            state_d  = K_IDLE;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        default: state_d = K_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= K_IDLE;
      digit1_q <= CODE_CLEAR;
      pw1_q    <= CODE_CLEAR;
      pw2_q    <= CODE_CLEAR;
      ready_q  <= 1'b0;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      digit1_q <= digit1_d;
      pw1_q    <= pw1_d;
      pw2_q    <= pw2_d;
      ready_q  <= ready_d;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign password_1 = pw1_q;
  assign password_2 = pw2_q;
  assign pass_ready = ready_q;
  assign entry_busy = (state_q == K_FIRST);
endmodule

// File: tb/tb_parking_input_conditioner.sv
// Directed bench for parking_input_conditioner with a sample-window sensor model and a digit-pair keypad model.
module tb_parking_input_conditioner;
  localparam int DC = 4;
  localparam int KT = 16;
  localparam int HL = DC + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       raw_entrance = 1'b0;
  logic       raw_exit = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'b00;
  logic       key_clear = 1'b0;
  logic       sensor_entrance, sensor_exit, pass_ready, entry_busy;
  logic [1:0] password_1, password_2;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  parking_input_conditioner #(.DEBOUNCE_CYCLES(DC), .KEY_TIMEOUT(KT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .raw_entrance    (raw_entrance),
    .raw_exit        (raw_exit),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_clear       (key_clear),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .pass_ready      (pass_ready),
    .entry_busy      (entry_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw sample history per channel; a sensor flips when the DC samples
  // that have passed the two-stage synchroniser all disagree with it.
  bit         he[HL];
  bit         hx[HL];
  bit         m_ent = 0, m_ext = 0, m_first = 0, m_rdy = 0;
  logic [1:0] m_d1 = 0, m_pw1 = 0, m_pw2 = 0;
  int         m_idle = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < HL; i++) begin he[i] = 0; hx[i] = 0; end
        m_ent = 0; m_ext = 0; m_first = 0; m_rdy = 0;
        m_d1 = 0; m_pw1 = 0; m_pw2 = 0; m_idle = 0;
      end else begin
        bit fe, fx;
        for (int i = HL - 1; i > 0; i--) begin he[i] = he[i-1]; hx[i] = hx[i-1]; end
        he[0] = raw_entrance;
        hx[0] = raw_exit;
        fe = 1; fx = 1;
        for (int i = 2; i < HL; i++) begin
          if (he[i] == m_ent) fe = 0;
          if (hx[i] == m_ext) fx = 0;
        end
        if (fe) m_ent = !m_ent;
        if (fx) m_ext = !m_ext;
        m_rdy = 0;
        if (key_clear) begin
          m_first = 0; m_pw1 = 0; m_pw2 = 0; m_idle = 0;
        end else if (key_valid) begin
          if (m_first) begin
            m_pw1 = m_d1; m_pw2 = key_code; m_rdy = 1; m_first = 0;
          end else begin
            m_d1 = key_code; m_first = 1; m_idle = 0;
          end
        end else if (m_first) begin
          m_idle++;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
          if (m_idle == KT) m_first = 0;
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && cmp_en) begin
        check("cmp_sensor_entrance", sensor_entrance, m_ent);
        check("cmp_sensor_exit", sensor_exit, m_ext);
        check("cmp_password_1", password_1, m_pw1);
        check("cmp_password_2", password_2, m_pw2);
        check("cmp_pass_ready", pass_ready, m_rdy);
        check("cmp_entry_busy", entry_busy, m_first);
      end
    end
  end

  task automatic press(input logic [1:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ent"}, sensor_entrance, 0);
    check({tag, "_ext"}, sensor_exit, 0);
    check({tag, "_pw1"}, password_1, 0);
    check({tag, "_pw2"}, password_2, 0);
    check({tag, "_rdy"}, pass_ready, 0);
    check({tag, "_busy"}, entry_busy, 0);
  endtask

  initial begin
    logic [1:0] burst [4];
    burst[0] = 2'b01; burst[1] = 2'b10; burst[2] = 2'b11; burst[3] = 2'b00;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    idle(2);

    // clean entrance edge: first sampled at edge 0, visible after edge 5
    raw_entrance = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ent_edge4", sensor_entrance, 0);
    @(posedge clk);
    @(negedge clk);
    check("ent_edge5", sensor_entrance, 1);
    idle(14);
    check("ent_held", sensor_entrance, 1);
    check("ext_quiet", sensor_exit, 0);
    raw_entrance = 1'b0;
    idle(10);
    check("ent_fall", sensor_entrance, 0);

    // 3-sample glitch rejected, 4-sample pulse passes and falls after 4 low samples
    raw_exit = 1'b1;
    idle(3);
    raw_exit = 1'b0;
    idle(10);
    check("ext_glitch3", sensor_exit, 0);
    raw_exit = 1'b1;
    idle(4);
    raw_exit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ext_pulse_rise", sensor_exit, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ext_pulse_hold", sensor_exit, 1);
    @(posedge clk);
    @(negedge clk);
    check("ext_pulse_fall", sensor_exit, 0);
    idle(2);

    // two-digit entry, keys 3 cycles apart
    press(2'b01);
    @(negedge clk);
    check("first_busy", entry_busy, 1);
    check("first_no_rdy", pass_ready, 0);
    idle(2);
    press(2'b10);
    @(negedge clk);
    check("pair_pw1", password_1, 2'b01);
    check("pair_pw2", password_2, 2'b10);
    check("pair_rdy", pass_ready, 1);
    check("pair_busy", entry_busy, 0);
    @(negedge clk);
    check("pair_rdy_pulse", pass_ready, 0);
    idle(1);
    press(2'b11);
    @(negedge clk);
    check("lone_pw1", password_1, 2'b01);
    check("lone_pw2", password_2, 2'b10);
    check("lone_busy", entry_busy, 1);

    // clear beats a simultaneous key
    key_clear = 1'b1; key_valid = 1'b1; key_code = 2'b10;
    @(posedge clk); #1;
    key_clear = 1'b0; key_valid = 1'b0;
    @(negedge clk);
    check("clr_busy", entry_busy, 0);
    check("clr_pw1", password_1, 0);
    check("clr_pw2", password_2, 0);
    check("clr_rdy", pass_ready, 0);
    idle(1);

    // 4-key burst publishes after keys 2 and 4
    for (int k = 0; k < 4; k++) begin
      key_valid = 1'b1;
      key_code  = burst[k];
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("burst_rdy%0d", k), pass_ready, (k % 2));
      if (k == 3) begin
        check("burst_pw1", password_1, 2'b11);
        check("burst_pw2", password_2, 2'b00);
      end
    end
    key_valid = 1'b0;
    idle(2);

    press(2'b01);
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("tmo_busy15", entry_busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("tmo_busy16", entry_busy, 0);
    check("tmo_pw1", password_1, 2'b11);
    check("tmo_rdy", pass_ready, 0);
    idle(1);
`else
    idle(100);
    check("no_tmo_busy", entry_busy, 1);
`endif

    // asynchronous reset mid-entry and mid-debounce
    key_clear = 1'b1;
    idle(1);
    key_clear = 1'b0;
    press(2'b10);
    press(2'b01);
    press(2'b11);
    raw_exit = 1'b1;
    idle(8);
    check("pre_rst_ext", sensor_exit, 1);
    check("pre_rst_busy", entry_busy, 1);
    raw_entrance = 1'b1;
    idle(2);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    raw_entrance = 1'b0;
    raw_exit = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);
    press(2'b01);
    press(2'b11);
    @(negedge clk);
    check("post_rst_pw1", password_1, 2'b01);
    check("post_rst_pw2", password_2, 2'b11);
    check("post_rst_rdy", pass_ready, 1);
    idle(3);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/parking_input_conditioner.md
# parking_input_conditioner

Front-end conditioning stage directly upstream of the parking gate controller. It synchronises and debounces the raw entrance and exit presence sensors into clean `sensor_entrance` and `sensor_exit` levels. It also assembles two 2-bit keypad digits into a stable `password_1`/`password_2` pair that the controller compares. All outputs are registered, and each output holds its value until a new decision is made.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatching cycles required before a sensor output flips; must be ≥ 2.
- `KEY_TIMEOUT`, default 16: idle cycles allowed between digit 1 and digit 2; used only when the timeout feature is compiled in.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `raw_entrance` in 1: raw entrance sensor; asynchronous, may bounce.
- `raw_exit` in 1: raw exit sensor; asynchronous, may bounce.
- `key_valid` in 1: one-cycle strobe meaning `key_code` is valid; synchronous to `clk`.
- `key_code` in 2: keypad digit.
- `key_clear` in 1: synchronous request to abort entry and clear the published code.
- `sensor_entrance` out 1: debounced entrance level.
- `sensor_exit` out 1: debounced exit level.
- `password_1` out 2: first published digit.
- `password_2` out 2: second published digit.
- `pass_ready` out 1: one-cycle pulse when a new pair is published.
- `entry_busy` out 1: high while exactly one digit of a new entry is held.

## Operation
- **Reset values:** every output is 0; `password_1` = `password_2` = 2'b00; keypad FSM is in `K_IDLE`; all counters are 0; synchroniser flops are 0.
- **Debounce, per channel (independent):**
  - A 2-FF synchroniser produces `s`.
  - When `s` differs from the output, the counter increments. When `s` equals the output, the counter resets to 0.
  - When `s` still differs and the counter equals `DEBOUNCE_CYCLES`-1, the output takes the value of `s` and the counter returns to 0.
  - Pulses shorter than `DEBOUNCE_CYCLES` synchronised cycles are therefore ignored.
- **Keypad FSM states:** `K_IDLE`, `K_FIRST`, `K_DONE`.
  - `K_IDLE` + `key_valid`: store `key_code` in a digit-1 buffer, go to `K_FIRST`.
  - `K_FIRST` + `key_valid`: load `password_1` from the buffer and `password_2` from `key_code` in the same edge, pulse `pass_ready`, go to `K_DONE`.
  - `K_DONE` + `key_valid`: start a new entry by storing digit 1 and going to `K_FIRST`. The published pair is held unchanged until the next publish or clear.
  - `key_clear` in any state: go to `K_IDLE`, drop the buffer, set `password_1` = `password_2` = 2'b00, force `pass_ready` to 0.
  - `key_clear` and `key_valid` in the same cycle: clear wins and the key is discarded.
  - `entry_busy` = (state == `K_FIRST`).
- The published pair never shows a half-updated code: both digits always change together.

## Timing
- **Sensor latency:** a clean level change sampled at edge 0 appears on the output after edge 1+`DEBOUNCE_CYCLES`. With the default, that is 5 cycles after the first sampling edge.
- **Keypad latency:** for a second digit sampled at edge N, `password_*` and `pass_ready` are valid in the cycle after edge N. `pass_ready` is high for exactly that one cycle.
- **Back-to-back keys:** `key_valid` on consecutive cycles is legal. A 4-key burst publishes twice, with `pass_ready` high in cycle 2 and cycle 4.
- **Asynchronous reset mid-entry:** takes effect immediately, with no partial publish.

## Configuration
- **Macro:** `PARKING_KEYPAD_TIMEOUT_EN`.
- **Defined:**
  - In `K_FIRST`, a counter increments on every cycle without `key_valid` and resets to 0 on entry to `K_FIRST`.
  - When the counter reaches `KEY_TIMEOUT`, the buffered digit is discarded and the FSM returns to `K_IDLE`.
  - `password_*` outputs are left unchanged and no `pass_ready` is issued.
  - If `key_valid` arrives in the same cycle the counter hits `KEY_TIMEOUT`, the key wins and is treated as digit 2.
- **Undefined:** `K_FIRST` waits indefinitely; the timeout counter logic is absent.

## Structure
- **Shared `parking_pkg`:** keypad-state enum (`K_IDLE`, `K_FIRST`, `K_DONE`), `KEY_W` = 2, `CODE_CLEAR` = 2'b00. The gate controller imports the same package.
- **Sub-module `sensor_debounce`:** synchroniser plus counter with parameter `DEBOUNCE_CYCLES`, instantiated twice (entrance and exit). The keypad FSM stays in the top module.

## Test plan
- **Clean entrance pulse:** `raw_entrance` 0→1 held 20 cycles with default params → `sensor_entrance` rises 5 cycles after the first sampling edge and stays high; `sensor_exit` stays 0.
- **Glitch rejection:** `raw_exit` high for 3 cycles → `sensor_exit` stays 0. Then high for 4 cycles → `sensor_exit` pulses high, and falls after the input has been low 4 synchronised cycles.
- **Two-digit entry:** keys 2'b01 then 2'b10, 3 cycles apart → `password_1`=01, `password_2`=10, one-cycle `pass_ready`; `entry_busy` high only between the keys. A following lone key 2'b11 → outputs still 01/10, `entry_busy`=1.
- **Clear priority:** in `K_FIRST`, assert `key_clear` and `key_valid`(2'b10) together → state is `K_IDLE`, outputs are 00/00, no `pass_ready`.
- **Timeout (`PARKING_KEYPAD_TIMEOUT_EN` defined, `KEY_TIMEOUT`=16):** key 2'b01, then silence → `entry_busy` drops after 16 cycles and outputs keep their prior values. With the macro undefined, `entry_busy` stays high through 100 idle cycles.
- **Reset mid-entry:** `reset_n` pulsed low while in `K_FIRST` and while a debounce counter is running → all outputs 0 immediately; the next two keys publish normally.
